tick_timer_scheduler: RTL and testbench

- Four-channel programmable millisecond timer scheduler driven by the 1 ms enable tick from the system clock divider.
- Each channel is armed with a duration and a one-shot or periodic mode, then counts down on tick_1ms.
- Expiries from all channels are serialised onto one valid/ready event port with round-robin arbitration.
- Consumers are the LCD message sequencing logic: message dwell timers, cursor blink and button debounce timeouts.

---
 rtl/tick_timer_scheduler.sv | 157 +++++++++++++++
 tb/tb_tick_timer_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer_scheduler.sv
// Four-channel millisecond timer scheduler.
// Each channel counts down on tick_1ms after being armed. Expiries are
// collected as pending/overrun flags and drained one per cycle onto a single
// valid/ready event port, using round-robin selection.
module tick_timer_scheduler #(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 16,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk_50m,
    input  logic              reset,
    input  logic              tick_1ms,
    input  logic              arm_valid,
    output logic              arm_ready,
    input  logic [CH_W-1:0]   arm_ch,
    input  logic [CNT_W-1:0]  arm_period,
    input  logic              arm_periodic,
    output logic              arm_err,
    input  logic              cancel_valid,
    input  logic [CH_W-1:0]   cancel_ch,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_overrun,
    output logic [NUM_CH-1:0] busy
);
    typedef enum logic {CH_IDLE = 1'b0, CH_RUNNING = 1'b1} ch_state_e;

    ch_state_e         r_state      [NUM_CH];
    ch_state_e         w_state_nxt  [NUM_CH];
    logic [CNT_W-1:0]  r_count      [NUM_CH];
    logic [CNT_W-1:0]  w_count_nxt  [NUM_CH];
    logic [CNT_W-1:0]  r_period     [NUM_CH];
    logic [CNT_W-1:0]  w_period_nxt [NUM_CH];
    logic [NUM_CH-1:0] r_periodic, w_periodic_nxt;
    logic [NUM_CH-1:0] r_pending,  w_pending_nxt;
    logic [NUM_CH-1:0] r_overrun,  w_overrun_nxt;
    logic [NUM_CH-1:0] w_arm_hit, w_cancel_hit, w_take;
    logic [CH_W-1:0]   r_rr, w_sel, w_idx;
    logic              w_found, w_load, w_arm_fire;
    logic              r_evt_valid, r_evt_overrun, r_arm_err;
    logic [CH_W-1:0]   r_evt_ch;

    assign arm_ready   = ~reset;
    assign w_arm_fire  = arm_valid & arm_ready;
    assign w_load      = ~r_evt_valid | evt_ready;
    assign evt_valid   = r_evt_valid;
    assign evt_ch      = r_evt_ch;
    assign evt_overrun = r_evt_overrun;
    assign arm_err     = r_arm_err;

    // Round-robin pick: first pending channel at or above the pointer, wrapping.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = r_rr + CH_W'(k);
            if (!w_found && r_pending[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Per-channel request decode; arm with a zero period is ignored here.
    always_comb begin
        w_arm_hit    = '0;
        w_cancel_hit = '0;
        w_take       = '0;
        busy         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_arm_hit[i]    = w_arm_fire && (arm_ch == CH_W'(i)) && (arm_period != '0);
            w_cancel_hit[i] = cancel_valid && (cancel_ch == CH_W'(i));
            w_take[i]       = w_load && w_found && (w_sel == CH_W'(i));
            busy[i]         = (r_state[i] == CH_RUNNING);
        end
    end

    // Channel next state: arm beats cancel beats tick. A flag taken by the
    // event port this cycle is cleared first, so a coincident expiry is a
    // fresh pending rather than an overrun.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_period_nxt   = r_period;
        w_periodic_nxt = r_periodic;
        w_pending_nxt  = r_pending;
        w_overrun_nxt  = r_overrun;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_take[i]) begin
                w_pending_nxt[i] = 1'b0;
                w_overrun_nxt[i] = 1'b0;
            end
            if (w_arm_hit[i]) begin
                w_state_nxt[i]    = CH_RUNNING;
                w_count_nxt[i]    = arm_period;
                w_period_nxt[i]   = arm_period;
                w_periodic_nxt[i] = arm_periodic;
            end else if (w_cancel_hit[i]) begin
                w_state_nxt[i]   = CH_IDLE;
                w_pending_nxt[i] = 1'b0;
                w_overrun_nxt[i] = 1'b0;
            end else if (tick_1ms && (r_state[i] == CH_RUNNING)) begin
                if (r_count[i] == CNT_W'(1)) begin
                    if (w_pending_nxt[i]) begin
                        w_overrun_nxt[i] = 1'b1;
                    end else begin
                        w_pending_nxt[i] = 1'b1;
                    end
                    if (r_periodic[i]) begin
                        w_count_nxt[i] = r_period[i];
                    end else begin
                        w_state_nxt[i] = CH_IDLE;
                    end
                end else begin
                    w_count_nxt[i] = r_count[i] - CNT_W'(1);
                end
            end
        end
    end

    // State registers and the event output register.
    always_ff @(posedge clk_50m) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]  <= CH_IDLE;
                r_count[i]  <= '0;
                r_period[i] <= '0;
            end
            r_periodic    <= '0;
            r_pending     <= '0;
            r_overrun     <= '0;
            r_rr          <= '0;
            r_evt_valid   <= 1'b0;
            r_evt_ch      <= '0;
            r_evt_overrun <= 1'b0;
            r_arm_err     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_period   <= w_period_nxt;
            r_periodic <= w_periodic_nxt;
            r_pending  <= w_pending_nxt;
            r_overrun  <= w_overrun_nxt;
            r_arm_err  <= w_arm_fire && (arm_period == '0);
            if (w_load) begin
                r_evt_valid <= w_found;
                if (w_found) begin
                    r_evt_ch      <= w_sel;
                    r_evt_overrun <= r_overrun[w_sel];
                    r_rr          <= w_sel + CH_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Bench for tick_timer_scheduler: table of single-channel vectors plus
// hand-written multi-cycle sequences; events checked through a scoreboard.
module tb_tick_timer_scheduler;
    logic        clk_50m = 1'b0;
    logic        reset = 1'b1;
    logic        tick_1ms = 1'b0;
    logic        arm_valid = 1'b0;
    logic        arm_ready;
    logic [1:0]  arm_ch = '0;
    logic [15:0] arm_period = '0;
    logic        arm_periodic = 1'b0;
    logic        arm_err;
    logic        cancel_valid = 1'b0;
    logic [1:0]  cancel_ch = '0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [1:0]  evt_ch;
    logic        evt_overrun;
    logic [3:0]  busy;

    tick_timer_scheduler dut (
        .clk_50m(clk_50m), .reset(reset), .tick_1ms(tick_1ms),
        .arm_valid(arm_valid), .arm_ready(arm_ready), .arm_ch(arm_ch),
        .arm_period(arm_period), .arm_periodic(arm_periodic), .arm_err(arm_err),
        .cancel_valid(cancel_valid), .cancel_ch(cancel_ch),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
        .evt_overrun(evt_overrun), .busy(busy)
    );

    always #5 clk_50m = ~clk_50m;

    typedef struct { logic [1:0] ch; logic ovr; } evt_t;
    typedef struct {
        int ch; int period; bit periodic; int n_ticks; int exp_events; bit exp_busy;
    } vec_t;

    evt_t sb[$];
    vec_t vecs[6];
    int   n_vec = 0;
    int   n_miss = 0;
    int   n_evt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Event monitor: every accepted event must match the scoreboard head.
    always @(negedge clk_50m) begin
        if (!reset && evt_valid && evt_ready) begin
            n_evt++;
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_event: got ch %0d ovr %0d, expected none", evt_ch, evt_overrun);
            end else begin
                evt_t e;
                e = sb.pop_front();
                check("evt_ch", 32'(evt_ch), 32'(e.ch));
                check("evt_overrun", 32'(evt_overrun), 32'(e.ovr));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_50m);
            #1;
        end
    endtask

    task automatic push(input int ch, input bit ovr);
        evt_t e;
        e.ch  = 2'(ch);
        e.ovr = ovr;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick_1ms = 1'b0; arm_valid = 1'b0; cancel_valid = 1'b0; evt_ready = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic arm(input int ch, input int period, input bit periodic);
        arm_valid = 1'b1; arm_ch = 2'(ch); arm_period = 16'(period); arm_periodic = periodic;
        cyc(1);
        arm_valid = 1'b0;
    endtask

    task automatic cancel(input int ch);
        cancel_valid = 1'b1; cancel_ch = 2'(ch);
        cyc(1);
        cancel_valid = 1'b0;
    endtask

    task automatic tick_only();
        tick_1ms = 1'b1;
        cyc(1);
        tick_1ms = 1'b0;
    endtask

    task automatic tick_gap();
        tick_only();
        cyc(4);
    endtask

    initial begin
        int start;
        vecs[0] = '{ch: 0, period: 3, periodic: 0, n_ticks: 5,  exp_events: 1, exp_busy: 0};
        vecs[1] = '{ch: 2, period: 2, periodic: 1, n_ticks: 4,  exp_events: 2, exp_busy: 1};
        vecs[2] = '{ch: 1, period: 1, periodic: 1, n_ticks: 3,  exp_events: 3, exp_busy: 1};
        vecs[3] = '{ch: 3, period: 4, periodic: 0, n_ticks: 3,  exp_events: 0, exp_busy: 1};
        vecs[4] = '{ch: 3, period: 4, periodic: 0, n_ticks: 4,  exp_events: 1, exp_busy: 0};
        vecs[5] = '{ch: 1, period: 7, periodic: 1, n_ticks: 14, exp_events: 2, exp_busy: 1};

        // Reset values
        cyc(1);
        check("rst_arm_ready", 32'(arm_ready), 0);
        check("rst_evt_valid", 32'(evt_valid), 0);
        check("rst_evt_ch", 32'(evt_ch), 0);
        check("rst_evt_overrun", 32'(evt_overrun), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_arm_err", 32'(arm_err), 0);
        reset = 1'b0;
        cyc(1);
        check("arm_ready_after_reset", 32'(arm_ready), 1);

        // Table-driven single-channel vectors
        foreach (vecs[v]) begin
            do_reset();
            evt_ready = 1'b1;
            arm(vecs[v].ch, vecs[v].period, vecs[v].periodic);
            start = n_evt;
            for (int t = 1; t <= vecs[v].n_ticks; t++) begin
                tick_only();
                if (vecs[v].periodic ? (t % vecs[v].period == 0) : (t == vecs[v].period))
                    push(vecs[v].ch, 1'b0);
                cyc(4);
            end
            cyc(3);
            check($sformatf("vec%0d_events", v), 32'(n_evt - start), 32'(vecs[v].exp_events));
            check($sformatf("vec%0d_busy", v), 32'(busy[vecs[v].ch]), 32'(vecs[v].exp_busy));
        end

        // One-shot latency: event two cycles after the expiring tick
        do_reset();
        arm(0, 3, 1'b0);
        check("busy0_armed", 32'(busy[0]), 1);
        tick_gap();
        tick_gap();
        tick_only();
        check("lat_valid_t1", 32'(evt_valid), 0);
        check("lat_busy0_fall", 32'(busy[0]), 0);
        push(0, 1'b0);
        cyc(1);
        check("lat_valid_t2", 32'(evt_valid), 1);
        check("lat_ch", 32'(evt_ch), 0);
        check("lat_ovr", 32'(evt_overrun), 0);
        evt_ready = 1'b1;
        cyc(2);
        evt_ready = 1'b0;
        check("lat_drained", 32'(evt_valid), 0);

        // Round robin from pointer 0
        do_reset();
        for (int c = 0; c < 4; c++) arm(c, 1, 1'b0);
        tick_only();
        for (int c = 0; c < 4; c++) push(c, 1'b0);
        cyc(2);
        check("rr0_first_ch", 32'(evt_ch), 0);
        evt_ready = 1'b1;
        start = n_evt;
        cyc(4);
        check("rr0_count", 32'(n_evt - start), 4);
        check("rr0_empty", 32'(evt_valid), 0);
        // Move pointer to 2 with a single ch1 event, then repeat
        arm(1, 1, 1'b0);
        tick_only();
        push(1, 1'b0);
        cyc(3);
        evt_ready = 1'b0;
        for (int c = 0; c < 4; c++) arm(c, 1, 1'b0);
        tick_only();
        push(2, 1'b0); push(3, 1'b0); push(0, 1'b0); push(1, 1'b0);
        cyc(2);
        check("rr2_first_ch", 32'(evt_ch), 2);
        evt_ready = 1'b1;
        start = n_evt;
        cyc(4);
        check("rr2_count", 32'(n_evt - start), 4);
        check("rr2_empty", 32'(evt_valid), 0);

        // Overrun: periodic period 1 with the consumer stalled for 3 ticks
        do_reset();
        arm(1, 1, 1'b1);
        tick_gap(); tick_gap(); tick_gap();
        check("ovr_first_valid", 32'(evt_valid), 1);
        check("ovr_first_ch", 32'(evt_ch), 1);
        check("ovr_first_flag", 32'(evt_overrun), 0);
        push(1, 1'b0);
        push(1, 1'b1);
        start = n_evt;
        evt_ready = 1'b1;
        cyc(6);
        check("ovr_count", 32'(n_evt - start), 2);
        cancel(1);

        // Zero-period arm is rejected; arm beats cancel; cancel stops expiry
        do_reset();
        evt_ready = 1'b1;
        arm(3, 0, 1'b0);
        check("arm_err_pulse", 32'(arm_err), 1);
        cyc(1);
        check("arm_err_clear", 32'(arm_err), 0);
        check("arm_err_busy3", 32'(busy[3]), 0);
        cancel_valid = 1'b1; cancel_ch = 2'd3;
        arm(3, 5, 1'b0);
        cancel_valid = 1'b0;
        check("arm_over_cancel", 32'(busy[3]), 1);
        start = n_evt;
        tick_gap(); tick_gap();
        cancel(3);
        check("cancel_busy3", 32'(busy[3]), 0);
        repeat (4) tick_gap();
        check("cancel_no_evt", 32'(n_evt - start), 0);

        // Arm coinciding with a tick reloads the full period
        do_reset();
        evt_ready = 1'b1;
        arm(0, 2, 1'b0);
        tick_gap();
        tick_1ms = 1'b1;
        arm(0, 2, 1'b0);
        tick_1ms = 1'b0;
        cyc(4);
        start = n_evt;
        tick_gap();
        check("arm_tick_still_busy", 32'(busy[0]), 1);
        check("arm_tick_no_evt", 32'(n_evt - start), 0);
        tick_only();
        push(0, 1'b0);
        cyc(4);
        check("arm_tick_expired", 32'(n_evt - start), 1);

        // Reset mid-operation drops the event and idles every channel
        do_reset();
        arm(0, 1, 1'b0);
        arm(1, 3, 1'b1);
        arm(2, 5, 1'b1);
        tick_only();
        cyc(2);
        check("midrst_pre_valid", 32'(evt_valid), 1);
        check("midrst_pre_busy", 32'(busy), 32'h6);
        reset = 1'b1;
        cyc(1);
        check("midrst_valid", 32'(evt_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_arm_ready", 32'(arm_ready), 0);
        reset = 1'b0;
        evt_ready = 1'b1;
        start = n_evt;
        repeat (6) tick_gap();
        check("midrst_no_evt", 32'(n_evt - start), 0);

        check("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
